keypoint_stream_out: RTL and testbench

- Reads the two keypoint SRAMs (2000x19) after detection has filled them, and serializes their contents onto the 16-bit out_valid/out_data output with an out_ready backpressure handshake.
- Sits after Detect_Filter_Keypoints and drives the core output pins.
- Counts come from the detection block.
- Stream per list: one header word, then two words per keypoint.

---
 rtl/keypoint_stream_out_if.sv | 10 +
 rtl/keypoint_stream_out.sv | 193 +++++++++++++++++++
 tb/tb_keypoint_stream_out.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypoint_stream_out_if.sv
// Output stream bundle for keypoint_stream_out.
// The word moves on a cycle where out_valid and out_ready are both high.
interface keypoint_stream_out_if;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/keypoint_stream_out.sv
// Streams both keypoint SRAMs as a header word plus (hi, lo) pairs per entry,
// through a 4-word output FIFO that has credit-based read issue.
module keypoint_stream_out #(
  parameter int ADDR_W = 11,
  parameter int KP_W   = 19,
  parameter int MAX_KP = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     kp1_count,
  input  logic [ADDR_W-1:0]     kp2_count,
  output logic [ADDR_W-1:0]     kp1_addr,
  input  logic [KP_W-1:0]       kp1_dout,
  output logic [ADDR_W-1:0]     kp2_addr,
  input  logic [KP_W-1:0]       kp2_dout,
  keypoint_stream_out_if.master stream,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_HDR2, S_RD2, S_FLUSH} state_t;

  localparam logic [ADDR_W-1:0] MAX_C = ADDR_W'(MAX_KP);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] c);
    return (c > MAX_C) ? MAX_C : c;
  endfunction

  function automatic logic [15:0] header_word(input logic list_id, input logic [ADDR_W-1:0] c);
    return {1'b1, list_id, 3'b000, 11'(c)};
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] kp1_addr_q, kp1_addr_d, kp2_addr_q, kp2_addr_d;
  logic              busy_q, busy_d, done_q, done_d;
  // v1: address on the SRAM pins this cycle; v2: its data is on dout this cycle
  logic              v1_q, v1_d, v2_q, v2_d;
  logic              sel1_q, sel1_d, sel2_q, sel2_d;
  logic [15:0]       mem_q [4];
  logic [15:0]       mem_d [4];
  logic [1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]        fifo_cnt_q, fifo_cnt_d;

  logic              pop;
  logic [1:0]        push_n;
  logic [1:0]        wr_ptr_p1;
  logic [2:0]        cnt_after_pop;
  logic [3:0]        occ;
  logic              read_ok, hdr_ok;
  logic [KP_W-1:0]   ret_kp;
  logic [ADDR_W-1:0] c1_in, c2_in;

  assign c1_in         = clamp_count(kp1_count);
  assign c2_in         = clamp_count(kp2_count);
  assign pop           = (fifo_cnt_q != 3'd0) && stream.out_ready;
  assign cnt_after_pop = fifo_cnt_q - {2'b00, pop};
  assign wr_ptr_p1     = wr_ptr_q + 2'd1;
  // Each read in flight already owns two FIFO slots
  assign occ           = {1'b0, cnt_after_pop} + {2'b00, v1_q, 1'b0} + {2'b00, v2_q, 1'b0};
  assign read_ok       = stream.out_ready && (occ <= 4'd2);
  assign hdr_ok        = stream.out_ready && !v1_q && !v2_q && (cnt_after_pop <= 3'd3);
  assign ret_kp        = sel2_q ? kp2_dout : kp1_dout;

  always_comb begin
    state_d    = state_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    rd_idx_d   = rd_idx_q;
    kp1_addr_d = kp1_addr_q;
    kp2_addr_d = kp2_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    v1_d       = 1'b0;
    sel1_d     = 1'b0;
    v2_d       = v1_q;
    sel2_d     = sel1_q;
    mem_d      = mem_q;
    push_n     = 2'd0;

    if (v2_q) begin
      mem_d[wr_ptr_q]  = {13'b0, ret_kp[18:16]};
      mem_d[wr_ptr_p1] = ret_kp[15:0];
      push_n           = 2'd2;
    end

    case (state_q)
      S_IDLE: begin
        kp1_addr_d = '0;
        kp2_addr_d = '0;
        // Header 1 goes straight into the FIFO so it is visible the next cycle
        if (start) begin
          c1_d            = c1_in;
          c2_d            = c2_in;
          busy_d          = 1'b1;
          rd_idx_d        = '0;
          mem_d[wr_ptr_q] = header_word(1'b0, c1_in);
          push_n          = 2'd1;
          state_d         = (c1_in == '0) ? S_HDR2 : S_RD1;
        end
      end
      S_RD1: begin
        if (read_ok) begin
          kp1_addr_d = rd_idx_q;
          rd_idx_d   = rd_idx_q + ONE_A;
          v1_d       = 1'b1;
          if (rd_idx_q == c1_q - ONE_A) state_d = S_HDR2;
        end
      end
      S_HDR2: begin
        kp1_addr_d = '0;
        // Wait for list-1 reads to land so header 2 is queued after them
        if (hdr_ok) begin
          mem_d[wr_ptr_q] = header_word(1'b1, c2_q);
          push_n          = 2'd1;
          rd_idx_d        = '0;
          state_d         = (c2_q == '0) ? S_FLUSH : S_RD2;
        end
      end
      S_RD2: begin
        if (read_ok) begin
          kp2_addr_d = rd_idx_q;
          rd_idx_d   = rd_idx_q + ONE_A;
          v1_d       = 1'b1;
          sel1_d     = 1'b1;
          if (rd_idx_q == c2_q - ONE_A) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        kp2_addr_d = '0;
        if (!v1_q && !v2_q && (cnt_after_pop == 3'd0)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_ptr_d   = rd_ptr_q + {1'b0, pop};
    wr_ptr_d   = wr_ptr_q + push_n;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push_n} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      c1_q       <= '0;
      c2_q       <= '0;
      rd_idx_q   <= '0;
      kp1_addr_q <= '0;
      kp2_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      sel1_q     <= 1'b0;
      sel2_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      rd_idx_q   <= rd_idx_d;
      kp1_addr_q <= kp1_addr_d;
      kp2_addr_q <= kp2_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      sel1_q     <= sel1_d;
      sel2_q     <= sel2_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign kp1_addr         = kp1_addr_q;
  assign kp2_addr         = kp2_addr_q;
  assign stream.out_valid = (fifo_cnt_q != 3'd0);
  assign stream.out_data  = (fifo_cnt_q != 3'd0) ? mem_q[rd_ptr_q] : 16'h0000;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_keypoint_stream_out.sv
// Bench for keypoint_stream_out: table of stream runs checked against a
// queue-based word model, plus hand sequences for literal stream and reset.
`timescale 1ns/1ps
module tb_keypoint_stream_out;
  localparam int MAXK = 2000;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [10:0] kp1_count, kp2_count, kp1_addr, kp2_addr;
  logic [18:0] kp1_dout, kp2_dout;
  logic        busy, done;

  always #5 clk = ~clk;

  keypoint_stream_out_if sif();

  keypoint_stream_out #(.ADDR_W(11), .KP_W(19), .MAX_KP(2000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .kp1_count(kp1_count), .kp2_count(kp2_count),
    .kp1_addr(kp1_addr), .kp1_dout(kp1_dout),
    .kp2_addr(kp2_addr), .kp2_dout(kp2_dout),
    .stream(sif), .busy(busy), .done(done)
  );

  logic [18:0] sram1 [2048];
  logic [18:0] sram2 [2048];

  always @(posedge clk) begin
    kp1_dout <= sram1[kp1_addr];
    kp2_dout <= sram2[kp2_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int done_cnt, done_lat;
  logic [10:0] max_a1, max_a2;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] ref_q[$];
  logic [15:0] s1_exp [12];

  typedef struct {
    int          c1;
    int          c2;
    int          rdy;
    bit          stretch;
    bit          disturb;
    logic [15:0] hdr1;
    logic [15:0] hdr2;
    int          nwords;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clampc(input int c);
    return (c > MAXK) ? MAXK : c;
  endfunction

  // Reference stream built straight from the word-format rules
  task automatic build_expected(input int c1, input int c2);
    int a, b;
    a = clampc(c1);
    b = clampc(c2);
    exp_q.delete();
    exp_q.push_back(16'h8000 | 16'(a));
    for (int i = 0; i < a; i++) begin
      exp_q.push_back(16'(sram1[i] >> 16));
      exp_q.push_back(sram1[i][15:0]);
    end
    exp_q.push_back(16'hC000 | 16'(b));
    for (int i = 0; i < b; i++) begin
      exp_q.push_back(16'(sram2[i] >> 16));
      exp_q.push_back(sram2[i][15:0]);
    end
  endtask

  task automatic run_stream(input int c1, input int c2, input int rdy_pct,
                            input bit stretch, input bit disturb);
    int n, budget, after;
    logic prev_stall, r;
    logic [15:0] pd;
    build_expected(c1, c2);
    got_q.delete();
    done_cnt = 0;
    done_lat = -1;
    max_a1 = '0;
    max_a2 = '0;
    budget = 30 * (clampc(c1) + clampc(c2)) + 200;
    @(posedge clk); #1;
    kp1_count = 11'(c1);
    kp2_count = 11'(c2);
    start = 1'b1;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    after = 0;
    prev_stall = 1'b0;
    pd = '0;
    while (n <= budget && after < 6) begin
      r = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      if (stretch && n >= 10 && n < 30) r = 1'b0;
      sif.out_ready = r;
      if (disturb) begin
        kp1_count = 11'($urandom);
        kp2_count = 11'($urandom);
        start = busy && ($urandom_range(3) == 0);
      end
      @(negedge clk);
      if (n == 1) begin
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_valid", 32'(sif.out_valid), 32'd1);
        check("lat_hdr1", 32'(sif.out_data), 32'(exp_q[0]));
      end
      if (prev_stall) check("stall_hold", {15'b0, sif.out_valid, sif.out_data}, {15'b0, 1'b1, pd});
      if (sif.out_valid && sif.out_ready) got_q.push_back(sif.out_data);
      prev_stall = sif.out_valid && !sif.out_ready;
      pd = sif.out_data;
      if (kp1_addr > max_a1) max_a1 = kp1_addr;
      if (kp2_addr > max_a2) max_a2 = kp2_addr;
      if (done) begin
        done_cnt++;
        if (done_lat < 0) done_lat = n;
      end
      if (done_cnt > 0) after++;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = -1;
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s_words: word %0d got %04h expected %04h", name, bad, got_q[bad], exp_q[bad]);
    end
  endtask

  task automatic check_s1(input string name);
    check({name, "_len"}, 32'(got_q.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_w%0d", name, i), 32'((i < got_q.size()) ? got_q[i] : 16'h0), 32'(s1_exp[i]));
  endtask

  task automatic load_s1_sram();
    sram1[0] = 19'h7FFFF;
    sram1[1] = 19'h12345;
    sram1[2] = 19'h40001;
    sram2[0] = 19'h00000;
    sram2[1] = 19'h5A5A5;
  endtask

  initial begin
    int idx, a, b;
    logic [15:0] h;
    s1_exp[0] = 16'h8003;  s1_exp[1] = 16'h0007;  s1_exp[2] = 16'hFFFF;
    s1_exp[3] = 16'h0001;  s1_exp[4] = 16'h2345;  s1_exp[5] = 16'h0004;
    s1_exp[6] = 16'h0001;  s1_exp[7] = 16'hC002;  s1_exp[8] = 16'h0000;
    s1_exp[9] = 16'h0000;  s1_exp[10] = 16'h0005; s1_exp[11] = 16'hA5A5;

    vt[0] = '{3,    2,    100, 1'b0, 1'b0, 16'h8003, 16'hC002, 12};
    vt[1] = '{0,    0,    100, 1'b0, 1'b0, 16'h8000, 16'hC000, 2};
    vt[2] = '{5,    5,    70,  1'b1, 1'b0, 16'h8005, 16'hC005, 22};
    vt[3] = '{2047, 1,    100, 1'b0, 1'b0, 16'h87D0, 16'hC001, 4004};
    vt[4] = '{0,    4,    100, 1'b0, 1'b0, 16'h8000, 16'hC004, 10};
    vt[5] = '{9,    0,    50,  1'b0, 1'b0, 16'h8009, 16'hC000, 20};
    vt[6] = '{6,    3,    100, 1'b0, 1'b1, 16'h8006, 16'hC003, 20};
    vt[7] = '{1,    2047, 60,  1'b0, 1'b0, 16'h8001, 16'hC7D0, 4004};

    for (int i = 0; i < 2048; i++) begin
      sram1[i] = 19'($urandom);
      sram2[i] = 19'($urandom);
    end

    rst_n = 1'b0;
    start = 1'b0;
    kp1_count = '0;
    kp2_count = '0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_data", 32'(sif.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", {10'b0, kp1_addr, kp2_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Literal stream of the reference example
    load_s1_sram();
    run_stream(3, 2, 100, 1'b0, 1'b0);
    check_s1("s1");
    $display("s1 stream: %0d words, done after %0d cycles", got_q.size(), done_lat);

    for (int v = 0; v < 8; v++) begin
      run_stream(vt[v].c1, vt[v].c2, vt[v].rdy, vt[v].stretch, vt[v].disturb);
      compare_stream($sformatf("vec%0d", v));
      a = clampc(vt[v].c1);
      b = clampc(vt[v].c2);
      h = (got_q.size() > 0) ? got_q[0] : 16'h0;
      check($sformatf("vec%0d_hdr1", v), 32'(h), 32'(vt[v].hdr1));
      idx = 1 + 2 * a;
      h = (got_q.size() > idx) ? got_q[idx] : 16'h0;
      check($sformatf("vec%0d_hdr2", v), 32'(h), 32'(vt[v].hdr2));
      check($sformatf("vec%0d_nwords", v), 32'(got_q.size()), 32'(vt[v].nwords));
      check($sformatf("vec%0d_addr1_peak", v), 32'(max_a1), 32'((a > 0) ? a - 1 : 0));
      check($sformatf("vec%0d_addr2_peak", v), 32'(max_a2), 32'((b > 0) ? b - 1 : 0));
      if (vt[v].rdy >= 100)
        check($sformatf("vec%0d_done_bound", v), 32'(done_lat >= 1 && done_lat <= 2 * (a + b) + 8), 32'd1);
      $display("vec%0d c1=%0d c2=%0d rdy=%0d: %0d words, done after %0d cycles",
               v, vt[v].c1, vt[v].c2, vt[v].rdy, got_q.size(), done_lat);
    end

    // Same counts with and without backpressure give the same words
    run_stream(5, 5, 100, 1'b0, 1'b0);
    ref_q = got_q;
    run_stream(5, 5, 70, 1'b1, 1'b0);
    compare_stream("s3");
    check("s3_same_as_ready", 32'(got_q == ref_q), 32'd1);
    $display("s3 stalled stream: %0d words, done after %0d cycles", got_q.size(), done_lat);

    // Reset in the middle of list 1, then a clean restart
    @(posedge clk); #1;
    kp1_count = 11'd50;
    kp2_count = 11'd2;
    start = 1'b1;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("s5_pre_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("s5_valid", 32'(sif.out_valid), 32'd0);
    check("s5_data", 32'(sif.out_data), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_done", 32'(done), 32'd0);
    check("s5_addr", {10'b0, kp1_addr, kp2_addr}, 32'd0);
    load_s1_sram();
    run_stream(3, 2, 100, 1'b0, 1'b0);
    check_s1("s5_restart");
    $display("s5 restart stream: %0d words, done after %0d cycles", got_q.size(), done_lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
